// File: rtl/pic186_pkg.sv
// Shared constants for the 80186-style interrupt controller: register word
// addresses (adr[4:1]), channel control layout and reset values.
package pic186_pkg;

  localparam logic [3:0] ADR_EOI    = 4'h1;  // 0x22
  localparam logic [3:0] ADR_MASK   = 4'h4;  // 0x28
  localparam logic [3:0] ADR_INSERV = 4'h6;  // 0x2C
  localparam logic [3:0] ADR_REQST  = 4'h7;  // 0x2E
  localparam logic [3:0] ADR_INTSTS = 4'h8;  // 0x30
  localparam logic [3:0] ADR_CTRL0  = 4'hC;  // 0x38, channel n at ADR_CTRL0+n

  localparam int PRI_W       = 3;
  localparam int CTL_W       = 5;
  localparam int EOI_NS_BIT  = 15;
  localparam int NMI_STS_BIT = 15;

  localparam logic [PRI_W-1:0] PRI_RST  = 3'b111;
  // One above the weakest priority: "nothing in service"
  localparam logic [PRI_W:0]   PRI_NONE = 4'd8;

  // Packing gives [2:0] pri, [3] mask, [4] level: the control register layout
  typedef struct packed {
    logic             level;
    logic             mask;
    logic [PRI_W-1:0] pri;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{level: 1'b0, mask: 1'b1, pri: PRI_RST};

  function automatic logic [PRI_W:0] pri_ext(input logic [PRI_W-1:0] p);
    return {1'b0, p};
  endfunction

endpackage

// File: rtl/pic_sync_edge.sv
// Request synchroniser for an active-low async input, followed by a registered
// assertion-edge detector. o_level is the synced level delayed to align with o_rise.
module pic_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_req_n,
  output logic o_level,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_dly;
  logic              r_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], ~i_req_n};
      r_dly  <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_dly;
    end
  end

  assign o_level = r_dly;
  assign o_rise  = r_rise;

endmodule

// File: rtl/wb_pic186.sv
// 80186-style interrupt controller on a Wishbone slave port: maskable channels with
// priority, edge/level mode, nested in-service tracking, EOI, INTA vector and an NMI.
import pic186_pkg::*;

module wb_pic186 #(
  parameter int         NUM_IRQ     = 4,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] VEC_BASE    = 8'd12,
  parameter logic [7:0] NMI_VEC     = 8'd2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wb_stb_i,
  input  logic               wb_cyc_i,
  input  logic               wb_we_i,
  input  logic [3:0]         wb_adr_i,
  input  logic [1:0]         wb_sel_i,
  input  logic [15:0]        wb_dat_i,
  output logic [15:0]        wb_dat_o,
  output logic               wb_ack_o,
  input  logic [NUM_IRQ-1:0] irq_n_i,
  input  logic               nmi_n_i,
  output logic               intr_o,
  input  logic               inta_i,
  output logic               nmi_o,
  input  logic               nmia_i,
  output logic [15:0]        vec_o
);

  // Handshake: a slave access is stb&cyc; ack rises one edge later for exactly one
  // cycle, and writes/read data are taken on that same edge.

  logic [NUM_IRQ-1:0] w_lvl, w_rise;
  logic               w_nmi_lvl, w_nmi_rise;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    pic_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_req_n (irq_n_i[g]),
      .o_level (w_lvl[g]),
      .o_rise  (w_rise[g])
    );
  end

  pic_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_nmi (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req_n (nmi_n_i),
    .o_level (w_nmi_lvl),
    .o_rise  (w_nmi_rise)
  );

  ctrl_t              r_ctrl [NUM_IRQ];
  logic [NUM_IRQ-1:0] r_pend, r_inserv;
  logic               r_nmi_pend, r_inta_d, r_nmia_d, r_intr, r_ack;
  logic [7:0]         r_vec;
  logic [15:0]        r_dat;

  logic               w_wr, w_rd, w_accept, w_any, w_inta_rise, w_nmia_rise;
  logic [PRI_W:0]     w_min_isr, w_best;
  logic [1:0]         w_isr_idx, w_win_idx;
  logic [NUM_IRQ-1:0] w_elig, w_isr_clr, w_isr_set;
  logic [15:0]        w_rdata;
  logic               w_unused;

  assign w_wr        = wb_stb_i & wb_cyc_i & wb_we_i & ~r_ack;
  assign w_rd        = wb_stb_i & wb_cyc_i & ~wb_we_i & ~r_ack;
  assign w_inta_rise = inta_i & ~r_inta_d;
  assign w_nmia_rise = nmia_i & ~r_nmia_d;
  assign w_unused    = &{1'b0, wb_dat_i[14:5], w_nmi_lvl};

  // Priority resolver: strongest in-service level gates all weaker-or-equal requests
  always_comb begin
    w_min_isr = PRI_NONE;
    w_isr_idx = '0;
    for (int n = 0; n < NUM_IRQ; n++) begin
      if (r_inserv[n] && (pri_ext(r_ctrl[n].pri) < w_min_isr)) begin
        w_min_isr = pri_ext(r_ctrl[n].pri);
        w_isr_idx = 2'(n);
      end
    end
    w_best    = PRI_NONE;
    w_win_idx = '0;
    w_elig    = '0;
    for (int n = 0; n < NUM_IRQ; n++) begin
      w_elig[n] = r_pend[n] & ~r_ctrl[n].mask & (pri_ext(r_ctrl[n].pri) < w_min_isr);
      if (w_elig[n] && (pri_ext(r_ctrl[n].pri) < w_best)) begin
        w_best    = pri_ext(r_ctrl[n].pri);
        w_win_idx = 2'(n);
      end
    end
  end

  assign w_any    = |w_elig;
  assign w_accept = w_inta_rise & w_any;

  // EOI and INSERV clears act on the old in-service set; acceptance is OR-ed in after
  always_comb begin
    w_isr_clr = '0;
    w_isr_set = '0;
    if (w_wr && (wb_adr_i == ADR_EOI)) begin
      for (int n = 0; n < NUM_IRQ; n++) begin
        if (wb_sel_i[1] && wb_dat_i[EOI_NS_BIT]) begin
          if (r_inserv[n] && (w_isr_idx == 2'(n))) w_isr_clr[n] = 1'b1;
        end else if (wb_sel_i[0] && (wb_dat_i[1:0] == 2'(n))) begin
          w_isr_clr[n] = 1'b1;
        end
      end
    end
    if (w_wr && (wb_adr_i == ADR_INSERV) && wb_sel_i[0])
      w_isr_clr = w_isr_clr | wb_dat_i[NUM_IRQ-1:0];
    for (int n = 0; n < NUM_IRQ; n++)
      if (w_accept && (w_win_idx == 2'(n))) w_isr_set[n] = 1'b1;
  end

  always_comb begin
    w_rdata = '0;
    case (wb_adr_i)
      ADR_MASK: for (int n = 0; n < NUM_IRQ; n++) w_rdata[n] = r_ctrl[n].mask;
      ADR_INSERV: w_rdata[NUM_IRQ-1:0] = r_inserv;
      ADR_REQST:  w_rdata[NUM_IRQ-1:0] = r_pend;
      ADR_INTSTS: w_rdata[NMI_STS_BIT] = r_nmi_pend;
      default: begin
        for (int n = 0; n < NUM_IRQ; n++)
          if (wb_adr_i == (ADR_CTRL0 + 4'(n))) w_rdata[CTL_W-1:0] = r_ctrl[n];
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NUM_IRQ; n++) r_ctrl[n] <= CTRL_RST;
      r_pend     <= '0;
      r_inserv   <= '0;
      r_nmi_pend <= 1'b0;
      r_inta_d   <= 1'b0;
      r_nmia_d   <= 1'b0;
      r_intr     <= 1'b0;
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_vec      <= VEC_BASE;
    end else begin
      r_ack    <= wb_stb_i & wb_cyc_i & ~r_ack;
      r_dat    <= w_rd ? w_rdata : 16'h0000;
      r_inta_d <= inta_i;
      r_nmia_d <= nmia_i;
      r_intr   <= w_any;
      r_inserv <= (r_inserv & ~w_isr_clr) | w_isr_set;

      if (!inta_i && !nmia_i)  r_vec <= VEC_BASE + {6'd0, w_win_idx};
      else if (w_nmia_rise)    r_vec <= NMI_VEC;

      if (w_nmi_rise)          r_nmi_pend <= 1'b1;
      else if (w_nmia_rise)    r_nmi_pend <= 1'b0;

      for (int n = 0; n < NUM_IRQ; n++) begin
        if (w_wr && wb_sel_i[0]) begin
          if (wb_adr_i == ADR_MASK) r_ctrl[n].mask <= wb_dat_i[n];
          if (wb_adr_i == (ADR_CTRL0 + 4'(n))) r_ctrl[n] <= ctrl_t'(wb_dat_i[CTL_W-1:0]);
        end
        if (r_ctrl[n].level)                          r_pend[n] <= w_lvl[n];
        else if (w_rise[n])                           r_pend[n] <= 1'b1;
        else if (w_accept && (w_win_idx == 2'(n)))    r_pend[n] <= 1'b0;
      end
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign intr_o   = r_intr;
  assign nmi_o    = r_nmi_pend;
  assign vec_o    = {8'h00, r_vec};

endmodule

// File: tb/tb_wb_pic186.sv
// Self-checking bench for wb_pic186: priority, nesting, level mode, NMI and the WB port.
module tb_wb_pic186;

  localparam logic [3:0] A_EOI    = 4'h1;
  localparam logic [3:0] A_UNMAP  = 4'h2;
  localparam logic [3:0] A_MASK   = 4'h4;
  localparam logic [3:0] A_INSERV = 4'h6;
  localparam logic [3:0] A_REQST  = 4'h7;
  localparam logic [3:0] A_INTSTS = 4'h8;
  localparam logic [3:0] A_C0     = 4'hC;
  localparam logic [3:0] A_C1     = 4'hD;
  localparam logic [3:0] A_C2     = 4'hE;
  localparam logic [3:0] A_C3     = 4'hF;

  logic        clk, reset_n;
  logic        wb_stb_i, wb_cyc_i, wb_we_i;
  logic [3:0]  wb_adr_i;
  logic [1:0]  wb_sel_i;
  logic [15:0] wb_dat_i, wb_dat_o;
  logic        wb_ack_o;
  logic [3:0]  irq_n_i;
  logic        nmi_n_i, intr_o, inta_i, nmi_o, nmia_i;
  logic [15:0] vec_o;

  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          last_lat = 0;
  logic [15:0] v;

  wb_pic186 dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_sel_i (wb_sel_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .irq_n_i  (irq_n_i),
    .nmi_n_i  (nmi_n_i),
    .intr_o   (intr_o),
    .inta_i   (inta_i),
    .nmi_o    (nmi_o),
    .nmia_i   (nmia_i),
    .vec_o    (vec_o)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Drivers: every task is entered and left at a falling edge
  task automatic wb_xfer(input logic [3:0] adr, input logic we, input logic [15:0] dat,
                         input logic [1:0] sel, output logic [15:0] rd, output logic ok);
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat; wb_sel_i = sel;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    ok = 1'b0; rd = '0; last_lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (wb_ack_o) begin
        ok = 1'b1; last_lat = i; rd = wb_dat_o;
        break;
      end
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic wb_write(input logic [3:0] adr, input logic [15:0] dat, input logic [1:0] sel);
    logic [15:0] rd;
    logic        ok;
    wb_xfer(adr, 1'b1, dat, sel, rd, ok);
    if (!ok) check_val("wr_noack", {15'd0, wb_ack_o}, 16'h0001);
  endtask

  task automatic wb_read(input string tag, input logic [3:0] adr, input logic [15:0] exp);
    logic [15:0] rd, e;
    logic        ok;
    exp_q.push_back(exp);
    wb_xfer(adr, 1'b0, 16'h0000, 2'b11, rd, ok);
    e = exp_q.pop_front();
    if (ok) check_val(tag, rd, e);
    else    check_val({tag, "_noack"}, {15'd0, wb_ack_o}, 16'h0001);
  endtask

  task automatic pulse_irq(input logic [3:0] lines, input int hold, input int settle);
    irq_n_i = ~lines;
    repeat (hold) @(negedge clk);
    irq_n_i = 4'hF;
    repeat (settle) @(negedge clk);
  endtask

  task automatic do_inta(output logic [15:0] vec);
    inta_i = 1'b1;
    @(negedge clk);
    vec = vec_o;
    inta_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_sel_i = '0; wb_dat_i = '0;
    irq_n_i = 4'hF; nmi_n_i = 1'b1; inta_i = 1'b0; nmia_i = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_intr", {15'd0, intr_o}, 16'h0000);
    check_val("rst_nmi",  {15'd0, nmi_o}, 16'h0000);
    check_val("rst_vec",  vec_o, 16'h000C);
    check_val("rst_ack",  {15'd0, wb_ack_o}, 16'h0000);
    check_val("rst_dat",  wb_dat_o, 16'h0000);
    reset_n = 1'b1;
    @(negedge clk);
    wb_read("rst_mask", A_MASK, 16'h000F);
    wb_read("rst_ctrl0", A_C0, 16'h000F);
    wb_read("rst_inserv", A_INSERV, 16'h0000);

    // 1: single edge request, latency and acknowledge
    wb_write(A_C0, 16'h0000, 2'b11);
    irq_n_i[0] = 1'b0;
    repeat (4) @(negedge clk);
    check_val("t1_intr_early", {15'd0, intr_o}, 16'h0000);
    @(negedge clk);
    check_val("t1_intr", {15'd0, intr_o}, 16'h0001);
    irq_n_i[0] = 1'b1;
    do_inta(v);
    check_val("t1_vec", v, 16'h000C);
    check_val("t1_intr_after", {15'd0, intr_o}, 16'h0000);
    wb_read("t1_inserv", A_INSERV, 16'h0001);
    wb_read("t1_reqst", A_REQST, 16'h0000);
    wb_write(A_EOI, 16'h8000, 2'b11);
    wb_read("t1_inserv_eoi", A_INSERV, 16'h0000);

    // 2: two requests together, higher priority first, lower blocked until EOI
    wb_write(A_C0, 16'h0002, 2'b11);
    wb_write(A_C2, 16'h0001, 2'b11);
    pulse_irq(4'b0101, 3, 3);
    check_val("t2_intr", {15'd0, intr_o}, 16'h0001);
    check_val("t2_vec_pre", vec_o, 16'h000E);
    do_inta(v);
    check_val("t2_vec", v, 16'h000E);
    check_val("t2_blocked", {15'd0, intr_o}, 16'h0000);
    wb_read("t2_inserv", A_INSERV, 16'h0004);
    wb_read("t2_reqst", A_REQST, 16'h0001);
    wb_write(A_EOI, 16'h8000, 2'b11);
    check_val("t2_intr_eoi", {15'd0, intr_o}, 16'h0001);
    do_inta(v);
    check_val("t2_vec0", v, 16'h000C);
    wb_write(A_EOI, 16'h8000, 2'b11);
    wb_read("t2_inserv_end", A_INSERV, 16'h0000);

    // 3: nesting
    wb_write(A_C1, 16'h0003, 2'b11);
    wb_write(A_C3, 16'h0001, 2'b11);
    wb_write(A_C2, 16'h0005, 2'b11);
    pulse_irq(4'b0010, 3, 3);
    do_inta(v);
    check_val("t3_vec1", v, 16'h000D);
    check_val("t3_intr_in1", {15'd0, intr_o}, 16'h0000);
    pulse_irq(4'b1000, 3, 3);
    check_val("t3_intr_nest", {15'd0, intr_o}, 16'h0001);
    do_inta(v);
    check_val("t3_vec3", v, 16'h000F);
    wb_read("t3_inserv", A_INSERV, 16'h000A);
    pulse_irq(4'b0100, 3, 3);
    check_val("t3_intr_low", {15'd0, intr_o}, 16'h0000);
    wb_read("t3_reqst", A_REQST, 16'h0004);
    wb_write(A_EOI, 16'h0003, 2'b11);
    check_val("t3_intr_eoi3", {15'd0, intr_o}, 16'h0000);
    wb_read("t3_inserv_eoi3", A_INSERV, 16'h0002);
    wb_write(A_EOI, 16'h0001, 2'b11);
    check_val("t3_intr_eoi1", {15'd0, intr_o}, 16'h0001);
    do_inta(v);
    check_val("t3_vec2", v, 16'h000E);
    wb_write(A_EOI, 16'h8000, 2'b11);
    wb_read("t3_inserv_end", A_INSERV, 16'h0000);

    // 4: level mode
    wb_write(A_C1, 16'h0013, 2'b11);
    irq_n_i[1] = 1'b0;
    repeat (6) @(negedge clk);
    check_val("t4_intr", {15'd0, intr_o}, 16'h0001);
    do_inta(v);
    check_val("t4_vec", v, 16'h000D);
    wb_read("t4_reqst_held", A_REQST, 16'h0002);
    irq_n_i[1] = 1'b1;
    repeat (3) @(negedge clk);
    wb_read("t4_reqst_before", A_REQST, 16'h0002);
    irq_n_i[1] = 1'b0;
    repeat (6) @(negedge clk);
    irq_n_i[1] = 1'b1;
    repeat (4) @(negedge clk);
    wb_read("t4_reqst_after", A_REQST, 16'h0000);
    wb_write(A_EOI, 16'h0001, 2'b11);
    wb_write(A_C1, 16'h000B, 2'b11);

    // 5: NMI with all channels masked
    wb_write(A_MASK, 16'h000F, 2'b01);
    nmi_n_i = 1'b0;
    repeat (3) @(negedge clk);
    nmi_n_i = 1'b1;
    repeat (3) @(negedge clk);
    check_val("t5_nmi", {15'd0, nmi_o}, 16'h0001);
    check_val("t5_intr", {15'd0, intr_o}, 16'h0000);
    wb_read("t5_intsts", A_INTSTS, 16'h8000);
    nmia_i = 1'b1;
    @(negedge clk);
    check_val("t5_vec", vec_o, 16'h0002);
    check_val("t5_nmi_clr", {15'd0, nmi_o}, 16'h0000);
    nmia_i = 1'b0;
    @(negedge clk);
    nmi_n_i = 1'b0;
    repeat (3) @(negedge clk);
    nmia_i = 1'b1;
    @(negedge clk);
    check_val("t5_nmi_same", {15'd0, nmi_o}, 16'h0001);
    nmia_i = 1'b0;
    nmi_n_i = 1'b1;
    @(negedge clk);
    nmia_i = 1'b1;
    @(negedge clk);
    nmia_i = 1'b0;
    check_val("t5_nmi_clr2", {15'd0, nmi_o}, 16'h0000);
    @(negedge clk);

    // 6: WB byte lanes, unmapped space, wait state
    wb_write(A_MASK, 16'h0000, 2'b10);
    check_val("t6_wr_lat", 16'(last_lat), 16'h0001);
    wb_read("t6_mask_hi", A_MASK, 16'h000F);
    check_val("t6_rd_lat", 16'(last_lat), 16'h0001);
    wb_write(A_MASK, 16'hFFF0, 2'b01);
    wb_read("t6_mask_lo0", A_MASK, 16'h0000);
    wb_write(A_MASK, 16'hFFFF, 2'b01);
    wb_read("t6_mask_lo1", A_MASK, 16'h000F);
    wb_read("t6_ctrl0_alias", A_C0, 16'h000A);
    wb_write(A_C3, 16'h0000, 2'b11);
    wb_read("t6_rd_3e", A_C3, 16'h0000);
    wb_read("t6_unmapped", A_UNMAP, 16'h0000);
    wb_read("t6_eoi_rd", A_EOI, 16'h0000);

    // 7: reset during an access
    wb_adr_i = A_MASK; wb_we_i = 1'b0; wb_sel_i = 2'b11;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    #2 reset_n = 1'b0;
    @(negedge clk);
    check_val("t7_ack_abandon", {15'd0, wb_ack_o}, 16'h0000);
    check_val("t7_vec", vec_o, 16'h000C);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    wb_read("t7_ctrl3", A_C3, 16'h000F);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
